// File: rtl/sd_data_tx_pkg.sv
// rtl/sd_data_tx_pkg.sv - shared state encoding, tokens and CRC16 step for the SD data-line engines
package sd_data_tx_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_PREFETCH    = 4'd1,
    S_START       = 4'd2,
    S_DATA        = 4'd3,
    S_CRC         = 4'd4,
    S_END         = 4'd5,
    S_WAIT_STATUS = 4'd6,
    S_STATUS      = 4'd7,
    S_BUSY        = 4'd8,
    S_DONE        = 4'd9
  } sd_tx_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  localparam logic [2:0] ST_ACCEPTED = 3'b010;
  localparam logic [2:0] ST_CRC_ERR  = 3'b101;
  localparam logic [2:0] ST_WR_ERR   = 3'b110;

  localparam logic [3:0] NIB_START = 4'h0;
  localparam logic [3:0] NIB_END   = 4'hF;
  localparam logic [3:0] NIB_IDLE  = 4'hF;

  // One MSB-first bit of CRC16-CCITT; feeding din = crc[15] degenerates to a plain left shift.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - 1-bit serial CRC16 (x^16+x^12+x^5+1, init 0) with synchronous clear and enable
module sd_crc16
  import sd_data_tx_pkg::*;
(
  input  logic        iclk,
  input  logic        irst,
  input  logic        iclr,
  input  logic        ien,
  input  logic        idin,
  output logic [15:0] ocrc
);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ocrc <= 16'h0000;
    end else if (iclr) begin
      ocrc <= 16'h0000;
    end else if (ien) begin
      ocrc <= crc16_step(ocrc, idin);
    end
  end

endmodule

// File: rtl/sd_data_tx.sv
// rtl/sd_data_tx.sv - SD write-direction data engine: block serialiser, per-line CRC16, status token and busy wait
module sd_data_tx
  import sd_data_tx_pkg::*;
#(
  parameter int BLOCK_NIBBLES  = 1024,
  parameter int STATUS_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT   = 65535
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       istart,
  output logic [9:0] oaddr,
  input  logic [3:0] irdata,
  input  logic [3:0] idata_sd,
  output logic [3:0] odata_sd,
  output logic       odata_sd_en,
  output logic       odone,
  output logic       oaccepted,
  output logic       oerror,
  output logic [2:0] ostatus
);

  localparam logic [9:0]  ADDR_LAST = 10'(BLOCK_NIBBLES - 1);
  localparam logic [15:0] DATA_LAST = 16'(BLOCK_NIBBLES - 1);
  localparam logic [15:0] CRC_LAST  = 16'd15;
  localparam logic [15:0] STAT_LAST = 16'(STATUS_TIMEOUT - 1);
  localparam logic [15:0] TOK_LAST  = 16'd3;
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

  sd_tx_state_t state, state_nxt;
  logic [15:0]  cnt;
  logic [3:0]   data_q;
  logic         crc_clr, crc_en, crc_shift;
  logic [15:0]  crc [4];
  logic         unused_dat;

  assign unused_dat = ^idata_sd[3:1];

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:        if (istart) state_nxt = S_PREFETCH;
      S_PREFETCH:    state_nxt = S_START;
      S_START:       state_nxt = S_DATA;
      S_DATA:        if (cnt == DATA_LAST) state_nxt = S_CRC;
      S_CRC:         if (cnt == CRC_LAST) state_nxt = S_END;
      S_END:         state_nxt = S_WAIT_STATUS;
      S_WAIT_STATUS: begin
        if (!idata_sd[0])           state_nxt = S_STATUS;
        else if (cnt == STAT_LAST)  state_nxt = S_DONE;
      end
      S_STATUS:      if (cnt == TOK_LAST) state_nxt = S_BUSY;
      S_BUSY:        if (idata_sd[0] || cnt == BUSY_LAST) state_nxt = S_DONE;
      S_DONE:        state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    odata_sd    = NIB_IDLE;
    odata_sd_en = 1'b0;
    odone       = 1'b0;
    crc_clr     = (state == S_PREFETCH);
    crc_en      = 1'b0;
    crc_shift   = 1'b0;
    unique case (state)
      S_START: begin
        odata_sd    = NIB_START;
        odata_sd_en = 1'b1;
      end
      S_DATA: begin
        odata_sd    = data_q;
        odata_sd_en = 1'b1;
        crc_en      = 1'b1;
      end
      S_CRC: begin
        odata_sd    = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};
        odata_sd_en = 1'b1;
        crc_en      = 1'b1;
        crc_shift   = 1'b1;
      end
      S_END: begin
        odata_sd    = NIB_END;
        odata_sd_en = 1'b1;
      end
      S_DONE:  odone = 1'b1;
      default: ;
    endcase
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt <= 16'd0;
    end else if (state == S_IDLE || state_nxt != state) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Address runs one cycle ahead of the registered RAM read plus the output stage.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      oaddr <= 10'd0;
    end else if (state == S_IDLE) begin
      if (istart) oaddr <= 10'd0;
    end else if (oaddr != ADDR_LAST) begin
      oaddr <= oaddr + 10'd1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      data_q <= 4'h0;
    end else begin
      data_q <= irdata;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_line
    sd_crc16 u_crc (
      .iclk (iclk),
      .irst (irst),
      .iclr (crc_clr),
      .ien  (crc_en),
      .idin (crc_shift ? crc[i][15] : data_q[i]),
      .ocrc (crc[i])
    );
  end

  // Error takes priority so accepted and error are mutually exclusive.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      oaccepted <= 1'b0;
      oerror    <= 1'b0;
      ostatus   <= 3'b000;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (istart) begin
            oaccepted <= 1'b0;
            oerror    <= 1'b0;
            ostatus   <= 3'b000;
          end
        end
        S_WAIT_STATUS: begin
          if (idata_sd[0] && cnt == STAT_LAST) oerror <= 1'b1;
        end
        S_STATUS: begin
          if (cnt != TOK_LAST) begin
            ostatus <= {ostatus[1:0], idata_sd[0]};
          end else if (idata_sd[0] && ostatus == ST_ACCEPTED) begin
            oaccepted <= 1'b1;
          end else begin
            oerror <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!idata_sd[0] && cnt == BUSY_LAST) begin
            oerror    <= 1'b1;
            oaccepted <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
